// File: rtl/sd_srv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_srv_pkg : shared types and constants for the SD sector server      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sd_srv_pkg;

  localparam int          c_sector_words   = 256;
  localparam logic [15:0] c_oor_read_value = 16'hFFFF;
  localparam int          c_ack_cnt_w      = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ACK_WAIT  = 4'd1,
    ST_RD_FETCH  = 4'd2,
    ST_RD_WAIT   = 4'd3,
    ST_RD_PUSH   = 4'd4,
    ST_WR_ADDR   = 4'd5,
    ST_WR_SAMPLE = 4'd6,
    ST_WR_WAIT   = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sd_sector_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_sector_server : serves 256-word sectors between an SD-style        |
// | initiator buffer and an external word-addressed backing store.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sd_sector_server
  import sd_srv_pkg::*;
#(
  parameter int LBA_BITS  = 4,
  parameter int ACK_DELAY = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [31:0]           sd_lba,
  input  logic                  sd_rd,
  input  logic                  sd_wr,
  output logic                  sd_ack,
  output logic [7:0]            sd_buff_addr,
  output logic [15:0]           sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [15:0]           sd_buff_din,
  output logic [LBA_BITS+7:0]   mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [15:0]           mem_din,
  input  logic [15:0]           mem_dout,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam logic [7:0]             c_last_word = 8'(c_sector_words - 1);
  localparam logic [c_ack_cnt_w-1:0] c_ack_delay = c_ack_cnt_w'(ACK_DELAY);
  localparam logic [c_ack_cnt_w-1:0] c_cnt_one   = c_ack_cnt_w'(1);

  state_t                 r_state, w_state_nxt;
  logic [c_ack_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]            r_lba, w_lba_nxt;
  logic                   r_is_rd, w_is_rd_nxt;
  logic                   r_ack, w_ack_nxt;
  logic [7:0]             r_addr, w_addr_nxt;
  logic [15:0]            r_dout, w_dout_nxt;
  logic [15:0]            r_mem_din, w_mem_din_nxt;
  logic                   r_mem_wr, w_mem_wr_nxt;
  logic                   w_oor;

  // Any latched sector bit beyond the served range disables the backing store.
  assign w_oor = (r_lba >> LBA_BITS) != 32'd0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lba     <= '0;
      r_is_rd   <= 1'b0;
      r_ack     <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_mem_din <= '0;
      r_mem_wr  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lba     <= w_lba_nxt;
      r_is_rd   <= w_is_rd_nxt;
      r_ack     <= w_ack_nxt;
      r_addr    <= w_addr_nxt;
      r_dout    <= w_dout_nxt;
      r_mem_din <= w_mem_din_nxt;
      r_mem_wr  <= w_mem_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_lba_nxt     = r_lba;
    w_is_rd_nxt   = r_is_rd;
    w_ack_nxt     = r_ack;
    w_addr_nxt    = r_addr;
    w_dout_nxt    = r_dout;
    w_mem_din_nxt = r_mem_din;
    w_mem_wr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sd_rd || sd_wr) begin
          w_lba_nxt   = sd_lba;
          w_is_rd_nxt = sd_rd;
          w_cnt_nxt   = c_ack_delay;
          w_state_nxt = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        w_cnt_nxt = r_cnt - c_cnt_one;
        if (r_cnt <= c_cnt_one) begin
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_addr_nxt  = '0;
          w_state_nxt = r_is_rd ? ST_RD_FETCH : ST_WR_ADDR;
        end
      end
      ST_RD_FETCH: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (w_oor) begin
          w_dout_nxt  = c_oor_read_value;
          w_state_nxt = ST_RD_PUSH;
        end else if (mem_ready) begin
          w_dout_nxt  = mem_dout;
          w_state_nxt = ST_RD_PUSH;
        end
      end
      ST_RD_PUSH: begin
        if (r_addr == c_last_word) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = ST_DONE;
        end else begin
          w_addr_nxt  = r_addr + 8'd1;
          w_state_nxt = ST_RD_FETCH;
        end
      end
      ST_WR_ADDR: w_state_nxt = ST_WR_SAMPLE;
      // The write strobe is registered so it lines up with the captured data.
      ST_WR_SAMPLE: begin
        w_mem_din_nxt = sd_buff_din;
        w_mem_wr_nxt  = !w_oor;
        w_state_nxt   = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (w_oor || mem_ready) begin
          if (r_addr == c_last_word) begin
            w_ack_nxt   = 1'b0;
            w_state_nxt = ST_DONE;
          end else begin
            w_addr_nxt  = r_addr + 8'd1;
            w_state_nxt = ST_WR_ADDR;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sd_ack       = r_ack;
  assign sd_buff_addr = r_addr;
  assign sd_buff_dout = r_dout;
  assign sd_buff_wr   = (r_state == ST_RD_PUSH);
  assign mem_addr     = {r_lba[LBA_BITS-1:0], r_addr};
  assign mem_rd       = (r_state == ST_RD_FETCH) && !w_oor;
  assign mem_wr       = r_mem_wr;
  assign mem_din      = r_mem_din;
  assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_sector_server : directed bench for sd_sector_server             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sd_sector_server;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_ready;
  logic        busy;

  sd_sector_server #(.LBA_BITS(4), .ACK_DELAY(2)) u_dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_ready    (mem_ready),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [15:0] bmem [0:4095];
  int          lat_max = 1;
  logic [31:0] cur_lba = 32'd0;

  // Backing store: pattern-filled, answers each strobe after 1..lat_max cycles.
  initial begin
    logic [11:0] a;
    logic        w;
    logic [15:0] d;
    int          lat;
    for (int i = 0; i < 4096; i++) bmem[i] = 16'(i);
    mem_ready = 1'b0;
    mem_dout  = 16'h0000;
    forever begin
      @(negedge clk_sys);
      if (mem_rd || mem_wr) begin
        a   = mem_addr;
        w   = mem_wr;
        d   = mem_din;
        lat = int'($urandom_range(lat_max, 1));
        repeat (lat) @(negedge clk_sys);
        if (w) bmem[a] = d;
        else   mem_dout = bmem[a];
        mem_ready = 1'b1;
        @(negedge clk_sys);
        mem_ready = 1'b0;
      end
    end
  end

  // Initiator buffer: returns ~addr one cycle after the address changes.
  initial begin
    logic [7:0] prev;
    prev        = 8'h00;
    sd_buff_din = 16'h0000;
    forever begin
      @(negedge clk_sys);
      sd_buff_din = ~{8'h00, prev};
      prev        = sd_buff_addr;
    end
  end

  int          n_mrd = 0, n_mwr = 0, n_bwr = 0;
  int          e_rd = 0, e_wr = 0, e_maddr = 0;
  int          low_run = 0, last_gap = 0;
  int          rd_idx = 0, wr_idx = 0, fetch_idx = 0;
  logic        prev_ack = 1'b0;
  logic [15:0] word5 = 16'h0;
  logic [11:0] addr5 = 12'h0;

  initial begin
    logic        oor;
    logic [15:0] exp_d;
    forever begin
      @(negedge clk_sys);
      oor = (cur_lba >> 4) != 32'd0;
      if (sd_ack && !prev_ack) begin
        rd_idx    = 0;
        wr_idx    = 0;
        fetch_idx = 0;
        last_gap  = low_run;
      end
      if (mem_rd) begin
        n_mrd++;
        if (mem_addr != {cur_lba[3:0], 8'(fetch_idx)}) e_maddr++;
        if (fetch_idx == 5) addr5 = mem_addr;
        fetch_idx++;
      end
      if (mem_wr) begin
        n_mwr++;
        if (mem_addr != {cur_lba[3:0], 8'(wr_idx)} || mem_din != ~{8'h00, 8'(wr_idx)}) e_wr++;
        wr_idx++;
      end
      if (sd_buff_wr) begin
        n_bwr++;
        exp_d = oor ? 16'hFFFF : bmem[{cur_lba[3:0], 8'(rd_idx)}];
        if (sd_buff_addr != 8'(rd_idx) || sd_buff_dout != exp_d) e_rd++;
        if (rd_idx == 5) word5 = sd_buff_dout;
        rd_idx++;
      end
      low_run  = sd_ack ? 0 : low_run + 1;
      prev_ack = sd_ack;
    end
  end

  int b_mrd, b_mwr, b_bwr, b_erd, b_ewr, b_emaddr;

  task automatic snap();
    b_mrd = n_mrd; b_mwr = n_mwr; b_bwr = n_bwr;
    b_erd = e_rd;  b_ewr = e_wr;  b_emaddr = e_maddr;
  endtask

  task automatic run_sector(input logic [31:0] lba, input logic rd, input logic wr,
                            input logic settle, output int ack_lat, output int gap,
                            output logic ok);
    int n;
    ok = 1'b1;
    ack_lat = 0;
    if (settle) repeat (3) @(negedge clk_sys);
    @(negedge clk_sys);
    cur_lba = lba;
    sd_lba  = lba;
    sd_rd   = rd;
    sd_wr   = wr;
    do begin
      @(posedge clk_sys); #1;
      ack_lat++;
    end while (!sd_ack && ack_lat < 50);
    if (!sd_ack) ok = 1'b0;
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    @(negedge clk_sys); #1;
    gap = last_gap;
    n = 0;
    while (sd_ack && n < 6000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (sd_ack) ok = 1'b0;
  endtask

  initial begin
    int   lat, gap, n;
    logic ok;
    reset  = 1'b1;
    sd_lba = 32'd0;
    sd_rd  = 1'b0;
    sd_wr  = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_ack",     32'(sd_ack), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_addr",    32'(sd_buff_addr), 32'd0);
    check("rst_dout",    32'(sd_buff_dout), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_strobes", 32'({sd_buff_wr, mem_rd, mem_wr}), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;

    // Plain read of sector 3.
    lat_max = 3;
    snap();
    run_sector(32'd3, 1'b1, 1'b0, 1'b0, lat, gap, ok);
    check("rd_done",    32'(ok), 32'd1);
    check("rd_ack_lat", lat, 32'd3);
    check("rd_bwr",     n_bwr - b_bwr, 32'd256);
    check("rd_mrd",     n_mrd - b_mrd, 32'd256);
    check("rd_mwr",     n_mwr - b_mwr, 32'd0);
    check("rd_data",    e_rd - b_erd, 32'd0);
    check("rd_maddr",   e_maddr - b_emaddr, 32'd0);
    check("rd_word5",   32'(word5), 32'h0305);
    check("rd_addr5",   32'(addr5), 32'h305);

    // Write of sector 15 with ~addr data.
    snap();
    run_sector(32'd15, 1'b0, 1'b1, 1'b1, lat, gap, ok);
    check("wr_done",    32'(ok), 32'd1);
    check("wr_ack_lat", lat, 32'd3);
    check("wr_mwr",     n_mwr - b_mwr, 32'd256);
    check("wr_bwr",     n_bwr - b_bwr, 32'd0);
    check("wr_data",    e_wr - b_ewr, 32'd0);
    repeat (8) @(negedge clk_sys);
    check("wr_mem_f00", 32'(bmem[12'hF00]), 32'hFFFF);
    check("wr_mem_f05", 32'(bmem[12'hF05]), 32'hFFFA);
    check("wr_mem_fff", 32'(bmem[12'hFFF]), 32'hFF00);

    // Read and write requested together resolve as a read.
    snap();
    run_sector(32'd1, 1'b1, 1'b1, 1'b1, lat, gap, ok);
    check("both_done", 32'(ok), 32'd1);
    check("both_mwr",  n_mwr - b_mwr, 32'd0);
    check("both_bwr",  n_bwr - b_bwr, 32'd256);
    check("both_data", e_rd - b_erd, 32'd0);

    // Out-of-range sector: read returns all ones, write is dropped.
    snap();
    run_sector(32'd16, 1'b1, 1'b0, 1'b1, lat, gap, ok);
    check("oor_rd_done", 32'(ok), 32'd1);
    check("oor_rd_mem",  (n_mrd - b_mrd) + (n_mwr - b_mwr), 32'd0);
    check("oor_rd_bwr",  n_bwr - b_bwr, 32'd256);
    check("oor_rd_data", e_rd - b_erd, 32'd0);
    snap();
    run_sector(32'h20, 1'b0, 1'b1, 1'b1, lat, gap, ok);
    check("oor_wr_done", 32'(ok), 32'd1);
    check("oor_wr_mwr",  n_mwr - b_mwr, 32'd0);
    check("oor_wr_mem0", 32'(bmem[12'h005]), 32'h0005);

    // Reset while word 100 of a read is being pushed.
    lat_max = 1;
    repeat (3) @(negedge clk_sys);
    cur_lba = 32'd2;
    sd_lba  = 32'd2;
    sd_rd   = 1'b1;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
      if (sd_ack) sd_rd = 1'b0;
    end while (!(sd_buff_wr && sd_buff_addr == 8'd100) && n < 3000);
    check("rst_mid_reached", 32'(sd_buff_addr), 32'd100);
    sd_rd = 1'b0;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("rst_mid_ack",  32'(sd_ack), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    snap();
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (6) @(negedge clk_sys);
    check("rst_mid_quiet", (n_mrd - b_mrd) + (n_mwr - b_mwr) + (n_bwr - b_bwr), 32'd0);
    snap();
    run_sector(32'd2, 1'b1, 1'b0, 1'b0, lat, gap, ok);
    check("rst_re_done", 32'(ok), 32'd1);
    check("rst_re_bwr",  n_bwr - b_bwr, 32'd256);
    check("rst_re_data", e_rd - b_erd, 32'd0);

    // Back-to-back sectors 0..15 with random memory latency.
    lat_max = 5;
    for (int s = 0; s < 16; s++) begin
      snap();
      run_sector(32'(s), 1'b1, 1'b0, 1'b0, lat, gap, ok);
      check("b2b_done", 32'(ok), 32'd1);
      check("b2b_bwr",  n_bwr - b_bwr, 32'd256);
      check("b2b_data", e_rd - b_erd + (e_maddr - b_emaddr), 32'd0);
      check("b2b_gap",  32'(gap >= 1), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
